load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/load_extend.sv | 34 +++
 rtl/load_store_unit.sv | 118 +++++++++++
 tb/tb_load_store_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, access sizes
// and the alignment rule used to classify faulting requests.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_FAULT  = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    // A request faults on the illegal size or on an address not aligned to its size.
    function automatic logic is_fault(input logic [1:0] size, input logic [1:0] addr_lo);
        logic fault;
        fault = 1'b0;
        case (size)
            SIZE_HALF: fault = addr_lo[0];
            SIZE_WORD: fault = (addr_lo != 2'b00);
            SIZE_BAD:  fault = 1'b1;
            default:   fault = 1'b0;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational extension of right-justified load data to 32 bits,
// sign- or zero-filling above the byte/halfword boundary.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic keep_half;
    logic keep_word;
    logic fill;

    // Illegal size never reaches here; it is treated like a word.
    assign keep_half = (size != SIZE_BYTE);
    assign keep_word = size[1];
    assign fill      = is_signed & ((size == SIZE_BYTE) ? data[7] : data[15]);

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bit
            if (gi < 8) begin : g_low
                assign result[gi] = data[gi];
            end else if (gi < 16) begin : g_mid
                assign result[gi] = keep_half ? data[gi] : fill;
            end else begin : g_high
                assign result[gi] = keep_word ? data[gi] : fill;
            end
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: registers a request, performs one
// RAM access (or faults it), and holds the response until it is taken.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    output logic        mem_enable,
    output logic        mem_rw,
    output logic [7:0]  mem_addr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic [15:0] access_count,
    output logic [7:0]  fault_count
);

    lsu_state_t  state_reg, state_next;
    logic        store_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [7:0]  addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] resp_data_reg;
    logic [15:0] access_count_reg;
    logic [7:0]  fault_count_reg;

    logic        accept;
    logic        in_access;
    logic        handshake;
    logic [31:0] load_value;

    assign accept    = req_valid && (state_reg == ST_IDLE);
    assign in_access = (state_reg == ST_ACCESS);
    assign handshake = resp_valid && resp_ready;

    load_extend u_extend (
        .data      (mem_dout),
        .size      (size_reg),
        .is_signed (signed_reg),
        .result    (load_value)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = is_fault(req_size, req_addr[1:0]) ? ST_FAULT : ST_ACCESS;
                end
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP, ST_FAULT: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            store_reg        <= 1'b0;
            size_reg         <= SIZE_BYTE;
            signed_reg       <= 1'b0;
            addr_reg         <= 8'd0;
            wdata_reg        <= 32'd0;
            resp_data_reg    <= 32'd0;
            access_count_reg <= 16'd0;
            fault_count_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                store_reg     <= req_store;
                size_reg      <= req_size;
                signed_reg    <= req_signed;
                addr_reg      <= req_addr;
                wdata_reg     <= req_wdata;
                resp_data_reg <= 32'd0;
            end
            if (in_access) begin
                resp_data_reg <= store_reg ? 32'd0 : load_value;
            end
            if (handshake && (state_reg == ST_RESP)) begin
                access_count_reg <= access_count_reg + 16'd1;
            end
            if (handshake && (state_reg == ST_FAULT) && (fault_count_reg != 8'hFF)) begin
                fault_count_reg <= fault_count_reg + 8'd1;
            end
        end
    end

    assign req_ready    = (state_reg == ST_IDLE);
    assign resp_valid   = (state_reg == ST_RESP) || (state_reg == ST_FAULT);
    assign resp_fault   = (state_reg == ST_FAULT);
    assign resp_data    = resp_valid ? resp_data_reg : 32'd0;
    assign mem_enable   = in_access;
    assign mem_rw       = in_access ? store_reg : 1'b0;
    assign mem_addr     = in_access ? addr_reg : 8'd0;
    assign mem_size     = in_access ? size_reg : 2'b00;
    assign mem_din      = in_access ? wdata_reg : 32'd0;
    assign access_count = access_count_reg;
    assign fault_count  = fault_count_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a big-endian RAM model plus a transaction-level
// byte-array reference that predicts responses, latency and counters.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic        mem_enable;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic [15:0] access_count;
    logic [7:0]  fault_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ram     [0:255];
    logic [7:0]  ref_mem [0:255];
    logic [15:0] exp_acc;
    logic [7:0]  exp_flt;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_fault   (resp_fault),
        .mem_enable   (mem_enable),
        .mem_rw       (mem_rw),
        .mem_addr     (mem_addr),
        .mem_size     (mem_size),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .access_count (access_count),
        .fault_count  (fault_count)
    );

    // RAM: combinational big-endian read, write on the clock edge
    always_comb begin
        mem_dout = 32'd0;
        if (mem_enable && !mem_rw) begin
            case (mem_size)
                2'b00:   mem_dout = {24'd0, ram[mem_addr]};
                2'b01:   mem_dout = {16'd0, ram[mem_addr], ram[mem_addr + 8'd1]};
                default: mem_dout = {ram[mem_addr], ram[mem_addr + 8'd1],
                                     ram[mem_addr + 8'd2], ram[mem_addr + 8'd3]};
            endcase
        end
    end

    always @(posedge clk) begin
        if (mem_enable && mem_rw) begin
            case (mem_size)
                2'b00: ram[mem_addr] <= mem_din[7:0];
                2'b01: begin
                    ram[mem_addr]        <= mem_din[15:8];
                    ram[mem_addr + 8'd1] <= mem_din[7:0];
                end
                default: begin
                    ram[mem_addr]        <= mem_din[31:24];
                    ram[mem_addr + 8'd1] <= mem_din[23:16];
                    ram[mem_addr + 8'd2] <= mem_din[15:8];
                    ram[mem_addr + 8'd3] <= mem_din[7:0];
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic ref_fault(input logic [1:0] size, input logic [7:0] addr);
        if (size == 2'b11) return 1'b1;
        if (size == 2'b01) return (addr % 2) != 0;
        if (size == 2'b10) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                             input logic [7:0] addr);
        logic [7:0]  a1, a2, a3;
        logic [7:0]  b;
        logic [15:0] h;
        a1 = addr + 8'd1;
        a2 = addr + 8'd2;
        a3 = addr + 8'd3;
        if (size == 2'b00) begin
            b = ref_mem[addr];
            return (sgn && b[7]) ? {24'hFFFFFF, b} : {24'd0, b};
        end
        if (size == 2'b01) begin
            h = {ref_mem[addr], ref_mem[a1]};
            return (sgn && h[15]) ? {16'hFFFF, h} : {16'd0, h};
        end
        return {ref_mem[addr], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [7:0] addr, input logic [31:0] wd);
        int n;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            ref_mem[8'(addr + 8'(i))] = wd[8*(n-1-i) +: 8];
        end
    endtask

    // One full transaction; entered and left at 1 time unit after a rising edge in IDLE.
    task automatic do_req(input logic st, input logic [1:0] size, input logic sgn,
                          input logic [7:0] addr, input logic [31:0] wd, input int hold);
        logic        flt;
        logic [31:0] exp_data;
        flt      = ref_fault(size, addr);
        exp_data = (flt || st) ? 32'd0 : ref_load(size, sgn, addr);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = 8'($urandom);
        check("req_ready_busy", {31'd0, req_ready}, 32'd0);
        if (flt) begin
            check("fault_no_enable", {31'd0, mem_enable}, 32'd0);
            check("fault_valid_n1", {31'd0, resp_valid}, 32'd1);
        end else begin
            check("access_enable", {31'd0, mem_enable}, 32'd1);
            check("access_rw", {31'd0, mem_rw}, {31'd0, st});
            check("access_addr", {24'd0, mem_addr}, {24'd0, addr});
            check("access_size", {30'd0, mem_size}, {30'd0, size});
            if (st) check("access_din", mem_din, wd);
            check("access_no_valid", {31'd0, resp_valid}, 32'd0);
            @(posedge clk);
            #1;
            check("resp_no_enable", {31'd0, mem_enable}, 32'd0);
        end
        for (int c = 0; c <= hold; c++) begin
            if (c == hold) resp_ready = 1'b1;
            check("resp_valid", {31'd0, resp_valid}, 32'd1);
            check("resp_data", resp_data, exp_data);
            check("resp_fault", {31'd0, resp_fault}, {31'd0, flt});
            check("resp_req_ready", {31'd0, req_ready}, 32'd0);
            check("resp_mem_idle", {31'd0, mem_enable}, 32'd0);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b0;
        if (flt) begin
            if (exp_flt != 8'hFF) exp_flt = exp_flt + 8'd1;
        end else begin
            exp_acc = exp_acc + 16'd1;
            if (st) ref_store(size, addr, wd);
        end
        check("back_idle", {31'd0, req_ready}, 32'd1);
        check("idle_no_valid", {31'd0, resp_valid}, 32'd0);
        check("access_count", {16'd0, access_count}, {16'd0, exp_acc});
        check("fault_count", {24'd0, fault_count}, {24'd0, exp_flt});
        $display("txn st=%0d size=%0d sgn=%0d addr=%02h wd=%08h hold=%0d fault=%0d data=%08h",
                 st, size, sgn, addr, wd, hold, flt, exp_data);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_resp_data"}, resp_data, 32'd0);
        check({tag, "_resp_fault"}, {31'd0, resp_fault}, 32'd0);
        check({tag, "_mem"}, {mem_enable, mem_rw, mem_size, 20'd0, mem_addr}, 32'd0);
        check({tag, "_mem_din"}, mem_din, 32'd0);
        check({tag, "_counts"}, {8'd0, fault_count, access_count}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[16'h10] = 8'h80; ram[16'h11] = 8'h12; ram[16'h12] = 8'h34; ram[16'h13] = 8'h56;
        for (int i = 16; i < 20; i++) ref_mem[i] = ram[i];
        exp_acc    = 16'd0;
        exp_flt    = 8'd0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 8'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("reset");

        // Faults first so fault_count reads 2 against a known zero start
        do_req(1'b0, 2'b10, 1'b1, 8'h11, 32'd0, 0);
        do_req(1'b0, 2'b11, 1'b0, 8'h00, 32'd0, 1);
        check("fault_count_two", {24'd0, fault_count}, 32'd2);

        do_req(1'b0, 2'b10, 1'b1, 8'h10, 32'd0, 0);
        do_req(1'b0, 2'b00, 1'b1, 8'h10, 32'd0, 0);
        do_req(1'b0, 2'b00, 1'b0, 8'h10, 32'd0, 0);
        do_req(1'b0, 2'b01, 1'b0, 8'h12, 32'd0, 0);
        do_req(1'b1, 2'b01, 1'b0, 8'h20, 32'h0000ABCD, 0);
        do_req(1'b0, 2'b01, 1'b0, 8'h20, 32'd0, 3);
        check("ram_word_known", {ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]}, 32'h80123456);
        check("access_count_six", {16'd0, access_count}, 32'd6);

        // Reset landing on the ACCESS cycle of a load
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 8'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst_in_access", {31'd0, mem_enable}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_acc = 16'd0;
        exp_flt = 8'd0;
        check_reset_outputs("rst_access");
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_resp", {31'd0, resp_valid}, 32'd0);

        for (int t = 0; t < 80; t++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 8'(8'h40 + $urandom_range(0, 15)),
                   $urandom, int'($urandom_range(0, 3)));
        end

        for (int t = 0; t < 258; t++) begin
            do_req(1'($urandom), 2'b11, 1'b0, 8'($urandom), $urandom, 0);
        end
        check("fault_saturated", {24'd0, fault_count}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
